// File: rtl/alu_muldiv_sequencer_if.sv
// alu_muldiv_sequencer_if: request/result and shared-ALU signals of the MUL/DIV sequencer
interface alu_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;
    logic             alu_own;
    logic [WIDTH-1:0] alu_srca;
    logic [WIDTH-1:0] alu_srcb;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output start, op, opa, opb, alu_result,
        input  busy, done, result_lo, result_hi, div_by_zero, alu_own, alu_srca, alu_srcb, alu_ctrl
    );
    modport slave (
        input  start, op, opa, opb, alu_result,
        output busy, done, result_lo, result_hi, div_by_zero, alu_own, alu_srca, alu_srcb, alu_ctrl
    );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: multi-cycle unsigned MUL/DIV that time-shares the core's single-cycle ALU.
// Define MULDIV_BYPASS_EN to finish trivial operands (x*0, 0*x, x*1, x/1) in one cycle without the ALU.
module alu_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_acc, r_sh, r_b, r_lo, r_hi;
    logic [CW-1:0]    r_cnt;
    logic             r_ge, r_dbz;
    logic             w_last, w_carry, w_div0, w_byp, w_fast, w_busy, w_div;
    logic [WIDTH-1:0] w_mul_acc, w_mul_sh, w_rem_s, w_rem_nx, w_quo_nx, w_byp_lo;

    // r_acc is the product high half (MUL) or partial remainder (DIV); r_sh is multiplier or quotient
    assign w_last    = r_cnt == LAST;
    assign w_busy    = r_state inside {MUL_STEP, DIV_CMP, DIV_SUB};
    assign w_div     = r_state inside {DIV_CMP, DIV_SUB};
    assign w_carry   = bus.alu_result < r_acc;
    assign w_mul_acc = r_sh[0] ? {w_carry, bus.alu_result[WIDTH-1:1]} : {1'b0, r_acc[WIDTH-1:1]};
    assign w_mul_sh  = {r_sh[0] ? bus.alu_result[0] : r_acc[0], r_sh[WIDTH-1:1]};
    assign w_rem_s   = {r_acc[WIDTH-2:0], r_sh[WIDTH-1]};
    assign w_rem_nx  = r_ge ? bus.alu_result : w_rem_s;
    assign w_quo_nx  = {r_sh[WIDTH-2:0], r_ge};
    assign w_div0    = bus.op && bus.opb == '0;
    assign w_fast    = w_div0 || w_byp;
`ifdef MULDIV_BYPASS_EN
    assign w_byp     = bus.op ? bus.opb == WIDTH'(1) : (bus.opa == '0 || bus.opb == '0 || bus.opb == WIDTH'(1));
    assign w_byp_lo  = bus.opb == WIDTH'(1) ? bus.opa : '0;
`else
    assign w_byp     = 1'b0;
    assign w_byp_lo  = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: start only matters in IDLE, so requests while busy or in DONE are dropped
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = !bus.start ? IDLE : w_fast ? DONE : bus.op ? DIV_CMP : MUL_STEP;
            MUL_STEP: w_next = w_last ? DONE : MUL_STEP;
            DIV_CMP:  w_next = DIV_SUB;
            DIV_SUB:  w_next = w_last ? DONE : DIV_CMP;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs: the ALU inputs are parked at 0/ADD whenever the block does not own the ALU
    always_comb begin
        bus.busy        = w_busy;
        bus.alu_own     = w_busy;
        bus.done        = r_state == DONE;
        bus.alu_ctrl    = r_state == DIV_CMP ? ALU_SLT : r_state == DIV_SUB ? ALU_SUB : ALU_ADD;
        bus.alu_srca    = r_state == MUL_STEP ? r_acc : w_div ? w_rem_s : '0;
        bus.alu_srcb    = w_busy ? r_b : '0;
        bus.result_lo   = r_lo;
        bus.result_hi   = r_hi;
        bus.div_by_zero = r_dbz;
    end

    // Datapath: operand capture, shift-add / restoring-divide steps, result latch on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sh  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_ge  <= 1'b0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_acc <= '0;
                    r_sh  <= bus.op ? bus.opa : bus.opb;
                    r_b   <= bus.op ? bus.opb : bus.opa;
                    r_cnt <= '0;
                    if (w_div0) begin
                        r_lo  <= '1;
                        r_hi  <= bus.opa;
                        r_dbz <= 1'b1;
                    end else if (w_byp) begin
                        r_lo  <= w_byp_lo;
                        r_hi  <= '0;
                        r_dbz <= 1'b0;
                    end
                end
                MUL_STEP: begin
                    r_acc <= w_mul_acc;
                    r_sh  <= w_mul_sh;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi  <= w_mul_acc;
                        r_lo  <= w_mul_sh;
                        r_dbz <= 1'b0;
                    end
                end
                DIV_CMP: r_ge <= r_acc[WIDTH-1] | ~bus.alu_result[0];
                DIV_SUB: begin
                    r_acc <= w_rem_nx;
                    r_sh  <= w_quo_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi  <= w_rem_nx;
                        r_lo  <= w_quo_nx;
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// tb_alu_muldiv_sequencer: table vectors, corner sequences and random ops against an arithmetic reference
module tb_alu_muldiv_sequencer;
    localparam int W = 32;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[11];

    alu_muldiv_sequencer_if #(.WIDTH(W)) ifc ();

    alu_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    // Core ALU stand-in; its SLT compares unsigned operands
    always_comb begin
        case (ifc.alu_ctrl)
            3'b001:  ifc.alu_result = ifc.alu_srca - ifc.alu_srcb;
            3'b101:  ifc.alu_result = {{(W-1){1'b0}}, ifc.alu_srca < ifc.alu_srcb};
            default: ifc.alu_result = ifc.alu_srca + ifc.alu_srcb;
        endcase
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ref_model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz, output int lat);
        logic [2*W-1:0] p;
        p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        dbz = op && b == 0;
        lo  = !op ? p[W-1:0] : dbz ? '1 : a / b;
        hi  = !op ? p[2*W-1:W] : dbz ? a : a % b;
        lat = dbz ? 1 : op ? 2*W+1 : W+1;
`ifdef MULDIV_BYPASS_EN
        if (op ? b == 1 : (a == 0 || b == 0 || b == 1)) lat = 1;
`endif
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge of the done cycle
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke,
                          output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz,
                          output int lat, output int nbusy, output int nown);
        ifc.start = 1'b1;
        ifc.op    = op;
        ifc.opa   = a;
        ifc.opb   = b;
        lat = 0;
        nbusy = 0;
        nown = 0;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(negedge clk);
            ifc.start = (k == poke);
            if (k == poke) begin
                ifc.op  = ~op;
                ifc.opa = ~a;
                ifc.opb = '0;
            end
            if (ifc.busy) nbusy++;
            if (ifc.alu_own !== ifc.busy) nown++;
            if (ifc.done) lat = k;
        end
        ifc.start = 1'b0;
        lo  = ifc.result_lo;
        hi  = ifc.result_hi;
        dbz = ifc.div_by_zero;
    endtask

    task automatic do_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edbz, input int poke);
        logic [W-1:0] lo, hi, mlo, mhi;
        logic         dbz, mdbz;
        int           lat, elat, nbusy, nown;
        ref_model(op, a, b, mlo, mhi, mdbz, elat);
        run_op(op, a, b, poke, lo, hi, dbz, lat, nbusy, nown);
        chk({tag, " lo"}, lo, elo);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " dbz"}, dbz, edbz);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " busy_cycles"}, nbusy, elat - 1);
        chk({tag, " own_vs_busy"}, nown, 0);
        @(negedge clk);
        chk({tag, " idle_flags"}, {ifc.done, ifc.busy, ifc.alu_own}, 0);
        chk({tag, " idle_alu"}, {ifc.alu_srca, ifc.alu_srcb, ifc.alu_ctrl}, 0);
        chk({tag, " hold"}, {ifc.div_by_zero, ifc.result_hi, ifc.result_lo}, {edbz, ehi, elo});
    endtask

    initial begin
        logic [W-1:0] a, b, mlo, mhi;
        logic         op, mdbz;
        int           mlat, ndone;
        tbl[0]  = '{1'b0, 32'd7,         32'd6,         32'd42,        32'd0,         1'b0};
        tbl[1]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFE,  1'b0};
        tbl[2]  = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        tbl[3]  = '{1'b1, 32'h80000000,  32'd3,         32'h2AAAAAAA,  32'd2,         1'b0};
        tbl[4]  = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
        tbl[5]  = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
        tbl[6]  = '{1'b0, 32'd9,         32'd1,         32'd9,         32'd0,         1'b0};
        tbl[7]  = '{1'b1, 32'd7,         32'd100,       32'd0,         32'd7,         1'b0};
        tbl[8]  = '{1'b0, 32'd0,         32'hDEADBEEF,  32'd0,         32'd0,         1'b0};
        tbl[9]  = '{1'b1, 32'hDEADBEEF,  32'd1,         32'hDEADBEEF,  32'd0,         1'b0};
        tbl[10] = '{1'b0, 32'h80000000,  32'd2,         32'd0,         32'd1,         1'b0};
        ifc.start = 1'b0;
        ifc.op    = 1'b0;
        ifc.opa   = '0;
        ifc.opb   = '0;
        repeat (3) @(negedge clk);
        chk("reset flags", {ifc.busy, ifc.done, ifc.div_by_zero, ifc.alu_own}, 0);
        chk("reset results", {ifc.result_hi, ifc.result_lo}, 0);
        chk("reset alu", {ifc.alu_srca, ifc.alu_srcb, ifc.alu_ctrl}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 11; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].dbz, 0);
        do_op("mul_ignored_start", 1'b0, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, 5);
        do_op("div_ignored_start", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 30);
        ifc.start = 1'b1;
        ifc.op    = 1'b0;
        ifc.opa   = 32'd3;
        ifc.opb   = 32'd5;
        ndone = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ifc.start = (k == 4);
            if (ifc.done) ndone++;
        end
        rst_n = 1'b0;
        ifc.start = 1'b0;
        @(negedge clk);
        chk("midop_reset flags", {ifc.busy, ifc.done, ifc.div_by_zero, ifc.alu_own}, 0);
        chk("midop_reset results", {ifc.result_hi, ifc.result_lo}, 0);
        chk("midop_reset alu", {ifc.alu_srca, ifc.alu_srcb, ifc.alu_ctrl}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifc.done || ifc.busy) ndone++;
        end
        chk("midop_reset no_done", ndone, 0);
        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(0, 15);
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = a;
            endcase
            ref_model(op, a, b, mlo, mhi, mdbz, mlat);
            do_op($sformatf("rnd%0d", i), op, a, b, mlo, mhi, mdbz, $urandom_range(0, 1) ? $urandom_range(2, 20) : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
